// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI master.
//   Command encodings, FSM state encoding, frame/data widths and a small
//   helper that decodes the slave-select level from the FSM state.
`timescale 1ns/1ps
package spi_pkg;

    localparam int FRAME_W = 10;    // {cmd[1:0], payload[7:0]}
    localparam int DATA_W  = 8;
    localparam int CMD_W   = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        CMDBIT   = 3'd2,
        SHIFT    = 3'd3,
        TURN     = 3'd4,
        CAPTURE  = 3'd5,
        DESELECT = 3'd6,
        GAPWAIT  = 3'd7
    } spi_state_e;

    // Slave select is asserted (low) from SELECT through CAPTURE.
    function automatic logic ss_n_of(input spi_state_e s);
        case (s)
            SELECT, CMDBIT, SHIFT, TURN, CAPTURE: return 1'b0;
            default:                              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/spi_master_shift.sv
// spi_master_shift -- serializer / deserializer datapath of the SPI master.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   load, frame : parallel load of the 10-bit outgoing frame
//   shift_en    : advance the serializer by one bit (MSB first)
//   mosi_bit    : current serializer MSB
//   cap_en      : shift one MISO bit into the deserializer
//   cap_last    : this capture is the eighth one; commit the byte to rd_data
//   miso        : serial input from the slave
//   rd_data     : last completed captured byte
`timescale 1ns/1ps
module spi_master_shift
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               shift_en,
    output logic               mosi_bit,
    input  logic               cap_en,
    input  logic               cap_last,
    input  logic               miso,
    output logic [DATA_W-1:0]  rd_data
);

    logic [FRAME_W-1:0] frame_q;
    // The deserializer holds the first seven received bits; the eighth bit
    // enters directly into rd_data together with them, so rd_data only ever
    // changes once per read and never shows a partially assembled byte.
    logic [DATA_W-2:0]  sr_q;
    logic [DATA_W-1:0]  rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            sr_q    <= '0;
            rd_q    <= '0;
        end else begin
            if (load) begin
                frame_q <= frame;
            end else if (shift_en) begin
                frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
            end
            if (cap_en) begin
                sr_q <= {miso, sr_q[DATA_W-2:1]};
                if (cap_last) begin
                    rd_q <= {miso, sr_q};
                end
            end
        end
    end

    assign mosi_bit = frame_q[FRAME_W-1];
    assign rd_data  = rd_q;

endmodule

// File: rtl/spi_master.sv
// spi_master -- single-slave SPI master issuing 10-bit command frames.
//   Parameters: TURNAROUND (idle cycles before MISO capture on a read-data),
//               GAP (minimum cycles SS_n stays high between transactions).
//   clk, rst_n     : system clock, asynchronous active-low reset
//   start, cmd,    : transaction request; {cmd, wdata} is latched on accept
//   wdata
//   busy, done     : busy from accept through the inter-frame gap, done pulse
//                    in the deselect cycle
//   rd_data        : byte captured on a read-data command (LSB received first)
//   SS_n, MOSI,    : SPI bus
//   MISO
//   txn_count      : completed-transaction counter, present only when the
//                    macro SPI_MASTER_TXN_COUNT_EN is defined
`timescale 1ns/1ps
module spi_master
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 1,
    parameter int GAP        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
`ifdef SPI_MASTER_TXN_COUNT_EN
    ,
    output logic [15:0]       txn_count
`endif
);

    localparam logic [3:0]  SHIFT_LAST = 4'(FRAME_W - 1);
    localparam logic [3:0]  CAP_LAST   = 4'(DATA_W - 1);
    localparam logic [15:0] TURN_LAST  = 16'(TURNAROUND - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP - 2);

    spi_state_e  state_q, state_d;
    spi_cmd_e    cmd_q;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic load, shift_en, cap_en, cap_last, mosi_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_WR_ADDR;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            if (load) begin
                cmd_q <= spi_cmd_e'(cmd);
            end
        end
    end

    // Counters are returned to zero on every state exit, so they never run
    // past their last value into an extra SHIFT/CAPTURE/TURN cycle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        load       = 1'b0;
        shift_en   = 1'b0;
        cap_en     = 1'b0;
        cap_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                state_d = CMDBIT;
            end
            CMDBIT: begin
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt_q == SHIFT_LAST) begin
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    if (cmd_q != CMD_RD_DATA) begin
                        state_d = DESELECT;
                    end else if (TURNAROUND == 0) begin
                        state_d = CAPTURE;
                    end else begin
                        state_d = TURN;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            TURN: begin
                if (wait_cnt_q == TURN_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                if (bit_cnt_q == CAP_LAST) begin
                    cap_last  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = DESELECT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            DESELECT: begin
                wait_cnt_d = '0;
                state_d    = (GAP <= 1) ? IDLE : GAPWAIT;
            end
            GAPWAIT: begin
                if (wait_cnt_q == GAP_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    spi_master_shift u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .frame    ({cmd, wdata}),
        .shift_en (shift_en),
        .mosi_bit (mosi_bit),
        .cap_en   (cap_en),
        .cap_last (cap_last),
        .miso     (MISO),
        .rd_data  (rd_data)
    );

    // Outputs decode straight from the state register so an asynchronous
    // reset releases the bus in the same cycle. In CMDBIT the serializer MSB
    // is cmd[1], which is exactly the write/read select bit.
    assign SS_n = ss_n_of(state_q);
    assign MOSI = (state_q == CMDBIT || state_q == SHIFT) ? mosi_bit : 1'b0;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DESELECT);

`ifdef SPI_MASTER_TXN_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (state_q == DESELECT) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- directed bench for spi_master against a small SPI slave
//   model holding a 256-byte RAM (RAM[0x59]=0x58, RAM[0x2E]=0x5A).
//   Optional macro SPI_MASTER_TXN_COUNT_EN enables the txn_count checks.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int TURNAROUND = 1;
    localparam int GAP        = 1;
    localparam int CAP_FIRST  = 12 + TURNAROUND;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       busy, done;
    logic [7:0] rd_data;
    logic       SS_n, MOSI, MISO;
`ifdef SPI_MASTER_TXN_COUNT_EN
    logic [15:0] txn_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #1 clk = ~clk;

    spi_master #(.TURNAROUND(TURNAROUND), .GAP(GAP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmd     (cmd),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO)
`ifdef SPI_MASTER_TXN_COUNT_EN
        ,
        .txn_count (txn_count)
`endif
    );

    // ---------------- SPI slave model ----------------
    // Cycle k of a select window (k = s_cnt): 0 select, 1 cmd bit,
    // 2..11 frame bits, then turnaround, then 8 data bits sent LSB first.
    logic [7:0] ram [256];
    logic [7:0] s_addr;
    logic [8:0] s_frame;
    logic [7:0] s_tx;
    int         s_cnt;

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 8'h00;
        ram[8'h59] = 8'h58;
        ram[8'h2E] = 8'h5A;
        s_addr = 8'h00;
        s_frame = '0;
        s_tx = 8'h00;
        s_cnt = 0;
    end

    always @(posedge clk) begin
        if (SS_n) begin
            s_cnt <= 0;
        end else begin
            s_cnt <= s_cnt + 1;
            if (s_cnt >= 2 && s_cnt <= 10) s_frame <= {s_frame[7:0], MOSI};
            if (s_cnt == 11) begin
                case (s_frame[8:7])
                    2'b00:   s_addr <= {s_frame[6:0], MOSI};
                    2'b01:   ram[s_addr] <= {s_frame[6:0], MOSI};
                    2'b10:   s_addr <= {s_frame[6:0], MOSI};
                    default: s_tx <= ram[s_addr];
                endcase
            end
            if (s_cnt >= CAP_FIRST && s_cnt < CAP_FIRST + 8) s_tx <= {1'b0, s_tx[7:1]};
        end
    end

    assign MISO = (!SS_n && s_cnt >= CAP_FIRST && s_cnt < CAP_FIRST + 8) ? s_tx[0] : 1'b0;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one request and follows it until busy drops.
    task automatic run_txn(input logic [1:0] c, input logic [7:0] w,
                           output int ss_low, output logic [11:0] mosi_bits,
                           output int dones, output logic timeout);
        int cyc;
        ss_low    = 0;
        mosi_bits = '0;
        dones     = 0;
        timeout   = 1'b0;
        start = 1'b1; cmd = c; wdata = w;
        @(negedge clk);
        start = 1'b0; cmd = ~c; wdata = ~w;   // must not disturb the frame
        for (cyc = 0; cyc < 200; cyc++) begin
            if (!busy) break;
            if (!SS_n) begin
                if (ss_low < 12) mosi_bits = {mosi_bits[10:0], MOSI};
                ss_low++;
            end
            if (done) dones++;
            @(negedge clk);
        end
        if (cyc >= 200) timeout = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [7:0]  wdata;
        int          ss_low;
        logic [11:0] mosi;    // select bit, cmd bit, then 10 frame bits
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          ss_low, dones;
        logic [11:0] mosi_bits;
        logic        timeout;

        vecs[0] = '{2'b00, 8'h59, 12, 12'h059, 8'h00};
        vecs[1] = '{2'b01, 8'h72, 12, 12'h172, 8'h00};
        vecs[2] = '{2'b10, 8'h2E, 12, 12'h62E, 8'h00};
        vecs[3] = '{2'b11, 8'h00, 21, 12'h700, 8'h5A};
        vecs[4] = '{2'b10, 8'h59, 12, 12'h659, 8'h5A};
        vecs[5] = '{2'b11, 8'h00, 21, 12'h700, 8'h72};

        rst_n = 1'b0; start = 1'b0; cmd = 2'b00; wdata = 8'h00;
        repeat (2) @(negedge clk);
        check("reset SS_n",    32'(SS_n),    32'd1);
        check("reset MOSI",    32'(MOSI),    32'd0);
        check("reset busy",    32'(busy),    32'd0);
        check("reset done",    32'(done),    32'd0);
        check("reset rd_data", 32'(rd_data), 32'h00);
`ifdef SPI_MASTER_TXN_COUNT_EN
        check("reset txn_count", 32'(txn_count), 32'd0);
`endif

        // Release reset and request straight away: accepted on the first edge.
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].cmd, vecs[i].wdata, ss_low, mosi_bits, dones, timeout);
            check($sformatf("vec%0d timeout", i), 32'(timeout), 32'd0);
            check($sformatf("vec%0d ss_low", i), 32'(ss_low), 32'(vecs[i].ss_low));
            check($sformatf("vec%0d mosi", i), 32'(mosi_bits), 32'(vecs[i].mosi));
            check($sformatf("vec%0d dones", i), 32'(dones), 32'd1);
            check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
            if (i == 1) check("ram[59] after write", 32'(ram[8'h59]), 32'h72);
        end
`ifdef SPI_MASTER_TXN_COUNT_EN
        check("txn_count after vectors", 32'(txn_count), 32'd6);
`endif

        // Reset in the middle of SHIFT bit 5 of a read-data transaction.
        start = 1'b1; cmd = 2'b11; wdata = 8'h00;
        @(negedge clk);                   // SELECT
        start = 1'b0;
        repeat (7) @(negedge clk);        // SHIFT bit 5
        check("pre-reset SS_n low", 32'(SS_n), 32'd0);
        rst_n = 1'b0;
        #0.5;
        check("midreset SS_n",    32'(SS_n),    32'd1);
        check("midreset busy",    32'(busy),    32'd0);
        check("midreset MOSI",    32'(MOSI),    32'd0);
        check("midreset done",    32'(done),    32'd0);
        check("midreset rd_data", 32'(rd_data), 32'h00);
        @(negedge clk);
        check("held reset rd_data", 32'(rd_data), 32'h00);
        rst_n = 1'b1;
        run_txn(2'b11, 8'h00, ss_low, mosi_bits, dones, timeout);
        check("post-reset timeout", 32'(timeout), 32'd0);
        check("post-reset ss_low",  32'(ss_low),  32'd21);
        check("post-reset dones",   32'(dones),   32'd1);
        check("post-reset rd_data", 32'(rd_data), 32'h72);

        // start held high across three back-to-back transactions.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int frames = 0, high_run = 0, min_high = 1000, total_low = 0;
            logic prev_ss = 1'b1;
            dones = 0;
            start = 1'b1; cmd = 2'b00; wdata = 8'h59;
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                if (!SS_n) begin
                    if (prev_ss) begin
                        if (frames > 0 && high_run < min_high) min_high = high_run;
                        frames++;
                    end
                    total_low++;
                    high_run = 0;
                end else begin
                    high_run++;
                end
                prev_ss = SS_n;
                if (done) begin
                    dones++;
                    if (dones == 3) start = 1'b0;
                end
            end
            check("held start frames",    32'(frames),    32'd3);
            check("held start dones",     32'(dones),     32'd3);
            check("held start ss_low",    32'(total_low), 32'd36);
            check("held start min gap",   32'(min_high >= GAP), 32'd1);
            check("held start idle busy", 32'(busy),      32'd0);
`ifdef SPI_MASTER_TXN_COUNT_EN
            check("held start txn_count", 32'(txn_count), 32'd3);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
